// File: rtl/eval_core_if.sv
// Heap read channel between eval_core (master) and the cons-cell memory (slave).
// The core holds addr from req until done; done marks valid header/car/cdr.
interface eval_core_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int HDR_W  = 15
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              done;
    logic [HDR_W-1:0]  header;
    logic [DATA_W-1:0] car;
    logic [DATA_W-1:0] cdr;

    modport master (output req, addr, input done, header, car, cdr);
    modport slave  (input req, addr, output done, header, car, cdr);
endinterface

// File: rtl/eval_core.sv
// Evaluates a number cell or a flat primitive application (op n1 n2 ...) from heap.
// Define EVAL_CORE_MUL_EN to enable opcode 2 (multiply); otherwise it is an apply error.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | request the expression cell
// WAIT     | waiting for mem.done, then go to cont_q
// DISPATCH | decode expression cell (number / cons / other)
// OP_FETCH | request the operator cell
// ARG_NEXT | end-of-list and arity check, request list cell or argument car
// ARG_EVAL | check the returned cell for step_q and accumulate
// DONE     | result valid
// ERROR    | error_code valid
module eval_core #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int HDR_W       = 15,
    parameter int NIL_ADDR    = 0,
    parameter int TYPE_NUMBER = 1,
    parameter int TYPE_CONS   = 2,
    parameter int TYPE_PRIM   = 3,
    parameter int MAX_ARGS    = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] expr_in,
    eval_core_if.master       mem,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        error_code,
    output logic [DATA_W-1:0] result
);
    localparam int CNT_W = $clog2(MAX_ARGS + 1);
    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
`ifdef EVAL_CORE_MUL_EN
    localparam logic [1:0] OP_MUL = 2'd2;
`endif

    localparam logic [3:0] ERR_STATE   = 4'd0;
    localparam logic [3:0] ERR_TIMEOUT = 4'd1;
    localparam logic [3:0] ERR_EVAL    = 4'd2;
    localparam logic [3:0] ERR_APPLY   = 4'd3;
    localparam logic [3:0] ERR_ARITY   = 4'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DISPATCH, S_OP_FETCH,
        S_ARG_NEXT, S_ARG_EVAL, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {STEP_OP, STEP_LIST, STEP_ARG} step_t;

    state_t            state_q, state_d, cont_q, cont_d;
    step_t             step_q, step_d;
    logic [ADDR_W-1:0] addr_q, addr_d, list_q, list_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [DATA_W-1:0] car_q, car_d, cdr_q, cdr_d;
    logic [DATA_W-1:0] acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [3:0]        err_q, err_d;
    logic              mem_req;
    logic              op_ok;
    logic              list_end;

`ifdef EVAL_CORE_MUL_EN
    assign op_ok = car_q <= DATA_W'(OP_MUL);
`else
    assign op_ok = car_q <= DATA_W'(OP_SUB);
`endif
    assign list_end = (step_q == STEP_LIST) && (list_q == ADDR_W'(NIL_ADDR));

    always_comb begin
        state_d  = state_q;
        cont_d   = cont_q;
        step_d   = step_q;
        addr_d   = addr_q;
        list_d   = list_q;
        hdr_d    = hdr_q;
        car_d    = car_q;
        cdr_d    = cdr_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        mem_req  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (expr_in == ADDR_W'(NIL_ADDR)) begin
                        result_d = DATA_W'(NIL_ADDR);
                        state_d  = S_DONE;
                    end else begin
                        addr_d  = expr_in;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                cont_d  = S_DISPATCH;
                tmr_d   = TMR_W'(MEM_TIMEOUT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.done) begin
                    hdr_d   = mem.header;
                    car_d   = mem.car;
                    cdr_d   = mem.cdr;
                    state_d = cont_q;
                end else if (tmr_q == '0) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERROR;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DISPATCH: begin
                if (hdr_q == HDR_W'(TYPE_NUMBER)) begin
                    result_d = car_q;
                    state_d  = S_DONE;
                end else if (hdr_q == HDR_W'(TYPE_CONS)) begin
                    list_d  = ADDR_W'(cdr_q);
                    addr_d  = ADDR_W'(car_q);
                    state_d = S_OP_FETCH;
                end else begin
                    err_d   = ERR_EVAL;
                    state_d = S_ERROR;
                end
            end
            S_OP_FETCH: begin
                mem_req = 1'b1;
                step_d  = STEP_OP;
                cont_d  = S_ARG_EVAL;
                tmr_d   = TMR_W'(MEM_TIMEOUT - 1);
                state_d = S_WAIT;
            end
            S_ARG_NEXT: begin
                if (list_end) begin
                    if (op_q == OP_SUB && cnt_q == '0) begin
                        err_d   = ERR_ARITY;
                        state_d = S_ERROR;
                    end else begin
                        result_d = (op_q == OP_SUB && cnt_q == CNT_W'(1)) ? -acc_q : acc_q;
                        state_d  = S_DONE;
                    end
                end else if (step_q == STEP_LIST && cnt_q == CNT_W'(MAX_ARGS)) begin
                    // one argument too many: refuse before fetching it
                    err_d   = ERR_ARITY;
                    state_d = S_ERROR;
                end else begin
                    mem_req = 1'b1;
                    cont_d  = S_ARG_EVAL;
                    tmr_d   = TMR_W'(MEM_TIMEOUT - 1);
                    state_d = S_WAIT;
                end
            end
            S_ARG_EVAL: begin
                err_d   = ERR_APPLY;
                state_d = S_ERROR;
                case (step_q)
                    STEP_OP: begin
                        if (hdr_q == HDR_W'(TYPE_PRIM) && op_ok) begin
                            op_d    = car_q[1:0];
`ifdef EVAL_CORE_MUL_EN
                            acc_d   = (car_q[1:0] == OP_MUL) ? DATA_W'(1) : '0;
`else
                            acc_d   = '0;
`endif
                            addr_d  = list_q;
                            step_d  = STEP_LIST;
                            err_d   = err_q;
                            state_d = S_ARG_NEXT;
                        end
                    end
                    STEP_LIST: begin
                        if (hdr_q == HDR_W'(TYPE_CONS)) begin
                            addr_d  = ADDR_W'(car_q);
                            list_d  = ADDR_W'(cdr_q);
                            step_d  = STEP_ARG;
                            err_d   = err_q;
                            state_d = S_ARG_NEXT;
                        end
                    end
                    STEP_ARG: begin
                        if (hdr_q == HDR_W'(TYPE_NUMBER)) begin
                            case (op_q)
                                OP_ADD:  acc_d = acc_q + car_q;
                                OP_SUB:  acc_d = (cnt_q == '0) ? car_q : acc_q - car_q;
`ifdef EVAL_CORE_MUL_EN
                                OP_MUL:  acc_d = acc_q * car_q;
`endif
                                default: acc_d = acc_q;
                            endcase
                            cnt_d   = cnt_q + CNT_W'(1);
                            addr_d  = list_q;
                            step_d  = STEP_LIST;
                            err_d   = err_q;
                            state_d = S_ARG_NEXT;
                        end
                    end
                    default: err_d = ERR_STATE;
                endcase
            end
            default: begin
                err_d   = ERR_STATE;
                state_d = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cont_q   <= S_IDLE;
            step_q   <= STEP_OP;
            addr_q   <= ADDR_W'(NIL_ADDR);
            list_q   <= ADDR_W'(NIL_ADDR);
            hdr_q    <= '0;
            car_q    <= '0;
            cdr_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            tmr_q    <= '0;
            err_q    <= ERR_STATE;
        end else begin
            state_q  <= state_d;
            cont_q   <= cont_d;
            step_q   <= step_d;
            addr_q   <= addr_d;
            list_q   <= list_d;
            hdr_q    <= hdr_d;
            car_q    <= car_d;
            cdr_q    <= cdr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
        end
    end

    assign mem.req    = mem_req;
    assign mem.addr   = addr_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign busy       = !(state_q == S_IDLE || done || error);
    assign error_code = err_q;
    assign result     = result_q;
endmodule
